fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 23 ++
 rtl/fifo_uart_baud_cnt.sv | 36 +++
 rtl/fifo_uart_tx.sv | 149 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-fed UART transmitter.
//   fifo_uart_state_e : transmitter FSM states
//   PAR_NONE/EVEN/ODD : values accepted by the PARITY parameter
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FETCH      = 3'd1,
      LOAD       = 3'd2,
      START      = 3'd3,
      DATA       = 3'd4,
      PARITY_BIT = 3'd5,
      STOP       = 3'd6
   } fifo_uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/fifo_uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// fifo_uart_baud_cnt
// Per-bit tick counter. Counts 0..CLKS_PER_BIT-1 and wraps; o_tick marks the
// last clk cycle of the current serial bit.
//   clk      : rising-edge clock
//   rst      : asynchronous, active-high reset
//   i_clear  : restart the count at 0 on the next edge (state entry)
//   o_tick   : high on the final cycle of a bit period
// ---------------------------------------------------------------------------
module fifo_uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_count;

   assign o_tick = (r_count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear || o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pulls words from a FIFO with registered read data and sends each as a UART
// frame: start bit, WIDTH data bits LSB-first, optional parity, one stop bit.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   enable      : allows new words to be fetched (checked in IDLE and at
//                 STOP exit only; a frame in flight always completes)
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO read data, valid the cycle after a pop
//   fifo_rd_en  : pop strobe, one cycle per word
//   tx          : serial line, idle high, registered
//   busy        : high whenever the FSM is not IDLE
//   done        : one-cycle pulse on the last cycle of each stop bit
//   o_state     : current FSM state, for debug/observation
//
// FIFO handshake: a pop is issued only when fifo_empty=0 was seen on the
// same edge that enters FETCH, so fifo_rd_en is never raised on an empty
// FIFO. fifo_rd_en is high for exactly the FETCH cycle; the popped word
// appears on fifo_data during LOAD and is captured at the end of LOAD.
// ---------------------------------------------------------------------------
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = PAR_NONE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             done,
   output fifo_uart_state_e o_state
);

   localparam int IW = $clog2(WIDTH) + 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

   fifo_uart_state_e r_state;
   fifo_uart_state_e w_next_state;

   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_next;
   logic [IW-1:0]    r_bit_idx;
   logic [IW-1:0]    w_bit_idx_next;
   logic             r_par;
   logic             w_par_next;
   logic             r_tx;
   logic             w_tx_next;
   logic             w_tick;
   logic             w_clear;
   logic             w_fetch_ok;

   assign w_fetch_ok = enable && !fifo_empty;

   // Restart the bit timer on every state change so each state's first
   // cycle is count 0; IDLE also holds it cleared instead of free-running.
   assign w_clear = (w_next_state != r_state) || (r_state == IDLE);

   fifo_uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_par     <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_next_state;
         r_shift   <= w_shift_next;
         r_bit_idx <= w_bit_idx_next;
         r_par     <= w_par_next;
         r_tx      <= w_tx_next;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      w_shift_next   = r_shift;
      w_bit_idx_next = r_bit_idx;
      w_par_next     = r_par;
      w_tx_next      = 1'b1;

      case (r_state)
         IDLE: begin
            if (w_fetch_ok) w_next_state = FETCH;
         end
         FETCH: begin
            w_next_state = LOAD;
         end
         LOAD: begin
            w_next_state   = START;
            w_shift_next   = fifo_data;
            w_bit_idx_next = '0;
            w_par_next     = (^fifo_data) ^ (PARITY == PAR_ODD);
         end
         START: begin
            if (w_tick) w_next_state = DATA;
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == LAST_BIT) begin
                  w_next_state = (PARITY != PAR_NONE) ? PARITY_BIT : STOP;
               end else begin
                  w_shift_next   = r_shift >> 1;
                  w_bit_idx_next = r_bit_idx + IW'(1);
               end
            end
         end
         PARITY_BIT: begin
            if (w_tick) w_next_state = STOP;
         end
         STOP: begin
            if (w_tick) w_next_state = w_fetch_ok ? FETCH : IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase

      // tx is registered, so it is computed from the state being entered;
      // this keeps the line aligned with r_state with no extra cycle of lag.
      case (w_next_state)
         START:      w_tx_next = 1'b0;
         DATA:       w_tx_next = w_shift_next[0];
         PARITY_BIT: w_tx_next = w_par_next;
         default:    w_tx_next = 1'b1;
      endcase
   end

   assign fifo_rd_en = (r_state == FETCH);
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == STOP) && w_tick;
   assign tx         = r_tx;
   assign o_state    = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Three transmitters (PARITY 0, 1, 2; WIDTH=8, CLKS_PER_BIT=4) share one FIFO
// word stream. Issued words go into exp_q; a per-instance monitor acts as a
// UART receiver and compares each frame, bit by bit, with the next word.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;
   import fifo_uart_pkg::*;

   localparam int W = 8;
   localparam int C = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_avail  = 0;
   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] tx_w, busy_w, done_w, rd_w, empty_w;
   logic [2:0][15:0] chk_w;
   logic [2:0][15:0] rd_ptr_w;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      exp_q.push_back(w);
      n_avail++;
   endtask

   // ---------------- DUTs, FIFO models, monitors ----------------
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int P  = g;
      localparam int NB = W + 2 + ((P != 0) ? 1 : 0);
      localparam int FL = NB * C;

      logic [W-1:0]     fdata = '0;
      logic             fempty;
      int               rd_ptr = 0;
      fifo_uart_state_e st;

      bit          in_frame = 0;
      bit          post = 0;
      bit          post_nxt = 0;
      int          k = 0;
      int          gap = 0;
      int          chk_idx = 0;
      int          bad_tx = 0;
      int          bad_done = 0;
      int          bad_busy = 0;
      logic [10:0] fb = '1;

      assign fempty      = (rd_ptr >= n_avail);
      assign empty_w[g]  = fempty;
      assign rd_ptr_w[g] = 16'(rd_ptr);
      assign chk_w[g]    = 16'(chk_idx);

      fifo_uart_tx #(
         .WIDTH(W),
         .CLKS_PER_BIT(C),
         .PARITY(P)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .enable     (enable),
         .fifo_empty (fempty),
         .fifo_data  (fdata),
         .fifo_rd_en (rd_w[g]),
         .tx         (tx_w[g]),
         .busy       (busy_w[g]),
         .done       (done_w[g]),
         .o_state    (st)
      );

      // FIFO with registered read data; not affected by the DUT reset.
      always @(posedge clk) begin
         if (rd_w[g]) begin
            if (rd_ptr < n_avail) fdata <= exp_q[rd_ptr];
            rd_ptr <= rd_ptr + 1;
         end
      end

      // UART receiver / frame checker
      always @(negedge clk) begin
         if (rst) begin
            in_frame = 0;
            post     = 0;
            chk_idx  = rd_ptr;   // word popped before reset is lost
         end else begin
            if (rd_w[g]) check($sformatf("p%0d_pop_on_empty", P), int'(fempty), 0);
            if (!in_frame) begin
               if (post) begin
                  gap++;
                  if (gap == 1) begin
                     if (post_nxt) begin
                        check($sformatf("p%0d_fetch_after_stop", P), int'(rd_w[g]), 1);
                     end else begin
                        check($sformatf("p%0d_idle_after_stop", P), int'(busy_w[g]), 0);
                        post = 0;
                     end
                  end
               end
               if (tx_w[g] == 1'b0) begin
                  if (post) begin
                     check($sformatf("p%0d_gap_before_start", P), gap, 3);
                     post = 0;
                  end
                  check($sformatf("p%0d_one_pop_per_frame", P), rd_ptr, chk_idx + 1);
                  fb = '1;
                  fb[0] = 1'b0;
                  if (chk_idx < exp_q.size()) begin
                     fb[8:1] = exp_q[chk_idx];
                     if (P != 0) fb[9] = (^exp_q[chk_idx]) ^ (P == 2);
                  end
                  in_frame = 1;
                  k = 0;
                  bad_tx = 0;
                  bad_done = 0;
                  bad_busy = 0;
               end else if (post && gap >= 3) begin
                  check($sformatf("p%0d_start_after_gap", P), 0, 1);
                  post = 0;
               end
            end
            if (in_frame) begin
               if (tx_w[g] !== fb[k / C]) bad_tx++;
               if (done_w[g] !== (k == FL - 1)) bad_done++;
               if (busy_w[g] !== 1'b1) bad_busy++;
               if (k == FL - 1) begin
                  check($sformatf("p%0d_frame_tx_bits", P), bad_tx, 0);
                  check($sformatf("p%0d_frame_done", P), bad_done, 0);
                  check($sformatf("p%0d_frame_busy", P), bad_busy, 0);
                  chk_idx++;
                  in_frame = 0;
                  post     = 1;
                  gap      = 0;
                  post_nxt = enable && (rd_ptr < n_avail);
               end else begin
                  k++;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int cnt = 0;
      do begin
         tick(1);
         cnt++;
      end while (!(busy_w == 3'b000 && empty_w == 3'b111) && cnt < 5000);
      check("idle_reached", int'(cnt < 5000), 1);
   endtask

   task automatic wait_start0();
      int cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (tx_w[0] !== 1'b0 && cnt < 200);
      check("start_seen", int'(cnt < 200), 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int viol;
      int cnt;

      rst = 1'b1;
      enable = 1'b0;
      tick(3);
      @(negedge clk);
      check("rst_tx", int'(tx_w), 7);
      check("rst_busy", int'(busy_w), 0);
      check("rst_rd_en", int'(rd_w), 0);
      check("rst_done", int'(done_w), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single word
      push_word(8'hA5);
      enable = 1'b1;
      wait_idle();

      // back-to-back pair
      push_word(8'h01);
      push_word(8'hFF);
      wait_idle();

      // parity pattern
      push_word(8'h07);
      wait_idle();

      // enable low with data waiting
      enable = 1'b0;
      for (int i = 0; i < 3; i++) push_word(W'($urandom_range(0, 255)));
      viol = 0;
      repeat (50) begin
         @(negedge clk);
         if (rd_w != 3'b000 || tx_w != 3'b111) viol++;
      end
      check("disabled_no_pop_tx_high", viol, 0);

      // enable dropped mid-frame
      @(posedge clk);
      #1;
      enable = 1'b1;
      wait_start0();
      tick(12);
      enable = 1'b0;
      cnt = 0;
      while (busy_w != 3'b000 && cnt < 200) begin
         tick(1);
         cnt++;
      end
      check("drop_enable_frame_ends", int'(cnt < 200), 1);
      tick(30);
      for (int i = 0; i < 3; i++) check($sformatf("p%0d_no_pop_after_drop", i), int'(rd_ptr_w[i]), n_avail - 2);
      enable = 1'b1;
      wait_idle();

      // reset during data bit 3
      push_word(W'($urandom_range(0, 255)));
      push_word(W'($urandom_range(0, 255)));
      wait_start0();
      repeat (17) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midframe_rst_tx", int'(tx_w), 7);
      check("midframe_rst_busy", int'(busy_w), 0);
      tick(2);
      rst = 1'b0;
      wait_idle();

      // random words, gaps and enable toggles
      repeat (16) begin
         push_word(W'($urandom_range(0, 255)));
         enable = ($urandom_range(0, 3) != 0);
         tick($urandom_range(1, 60));
      end
      enable = 1'b1;
      wait_idle();
      tick(5);

      for (int i = 0; i < 3; i++) check($sformatf("p%0d_all_frames_sent", i), int'(chk_w[i]), n_avail);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, actual running required finished");
      $fatal(1, "watchdog");
   end

endmodule
